// File: rtl/pair_match_gen_if.sv
// pair_match_gen_if: control/link bundle for the X/Y pair-match generator.
//   master : board control side, drives start/run_in/abort and observes the link.
//   slave  : generator side, drives x/y and the status flags.
//   start, run_in, abort   request a burst, set its length, or cut it short
//   x, y, valid            link bit pair and its burst qualifier
//   busy, done, short, err status: burst active, end pulse, aborted flag, bad-length pulse
interface pair_match_gen_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] run_in;
    logic             abort;
    logic             x;
    logic             y;
    logic             valid;
    logic             busy;
    logic             done;
    logic             short;
    logic             err;

    modport master (
        output start, run_in, abort,
        input  x, y, valid, busy, done, short, err
    );

    modport slave (
        input  start, run_in, abort,
        output x, y, valid, busy, done, short, err
    );
endinterface

// File: rtl/pair_match_gen.sv
// pair_match_gen: transmit side of the X/Y pair-match link.
// On an accepted start it emits one guard mismatch pair (LEAD), run_in matching
// pairs carrying LFSR data (MATCH), and one closing mismatch pair (TAIL), then
// pulses done. All outputs are registered.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  pair_match_gen_if.slave (start/run_in/abort in; x/y/valid/busy/done/short/err out)
module pair_match_gen #(
    parameter int         CNT_W = 4,
    parameter logic [7:0] SEED  = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    pair_match_gen_if.slave    bus
);
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

    typedef enum logic [1:0] {IDLE, LEAD, MATCH, TAIL} state_t;

    state_t           state;
    logic [7:0]       lfsr;
    logic [7:0]       lfsr_nxt;
    logic [CNT_W-1:0] cnt;
    logic             aborted;
    logic             x_r, y_r, valid_r, busy_r, done_r, short_r, err_r;

    // Fibonacci taps 8,6,5,4; the fresh feedback bit enters at bit 0.
    assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // Outputs are loaded with the values of the state being entered, so the
    // pair seen in a cycle always belongs to the state of that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lfsr    <= SEED_EFF;
            cnt     <= '0;
            aborted <= 1'b0;
            x_r     <= 1'b0;
            y_r     <= 1'b1;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            short_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            short_r <= 1'b0;
            err_r   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.run_in != '0) begin
                            state   <= LEAD;
                            cnt     <= bus.run_in;
                            aborted <= 1'b0;
                            x_r     <= lfsr[0];
                            y_r     <= ~lfsr[0];
                            valid_r <= 1'b1;
                            busy_r  <= 1'b1;
                        end else begin
                            err_r   <= 1'b1;
                        end
                    end
                end
                LEAD: begin
                    // LFSR holds here: LEAD and the first MATCH share data bit.
                    x_r <= lfsr[0];
                    if (bus.abort) begin
                        state   <= TAIL;
                        aborted <= 1'b1;
                        y_r     <= ~lfsr[0];
                    end else begin
                        state   <= MATCH;
                        y_r     <= lfsr[0];
                    end
                end
                MATCH: begin
                    lfsr <= lfsr_nxt;
                    cnt  <= cnt - 1'b1;
                    x_r  <= lfsr_nxt[0];
                    // cnt==1 means this is the last matching pair; cnt never
                    // reaches 0 inside MATCH, so it cannot wrap.
                    if (bus.abort || cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state <= TAIL;
                        y_r   <= ~lfsr_nxt[0];
                        if (bus.abort)
                            aborted <= 1'b1;
                    end else begin
                        y_r   <= lfsr_nxt[0];
                    end
                end
                TAIL: begin
                    state   <= IDLE;
                    x_r     <= 1'b0;
                    y_r     <= 1'b1;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    short_r <= aborted;
                end
                default: begin
                    state   <= IDLE;
                    x_r     <= 1'b0;
                    y_r     <= 1'b1;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x     = x_r;
    assign bus.y     = y_r;
    assign bus.valid = valid_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.short = short_r;
    assign bus.err   = err_r;
endmodule

// File: tb/tb_pair_match_gen.sv
// tb_pair_match_gen: directed bench for pair_match_gen. One DUT with the
// default seed, one with SEED=0; expected link data comes from a golden LFSR.
module tb_pair_match_gen;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    logic [7:0] m_l;
    logic [7:0] m_l0;
    int   n_match;

    pair_match_gen_if #(.CNT_W(4)) p ();
    pair_match_gen_if #(.CNT_W(4)) p0 ();

    pair_match_gen #(.CNT_W(4), .SEED(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (p)
    );

    pair_match_gen #(.CNT_W(4), .SEED(8'h00)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (p0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lstep(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs the link state as {valid, busy, done, short, err, x, y}.
    function automatic logic [6:0] st(input logic v, b, d, s, e, x, y);
        return {v, b, d, s, e, x, y};
    endfunction

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1;
        p.start = 1'b0;  p.run_in = '0;  p.abort = 1'b0;
        p0.start = 1'b0; p0.run_in = '0; p0.abort = 1'b0;
        m_l = 8'hA5; m_l0 = 8'h01;

        // Test 1: reset, then a RUN_IN=8 burst.
        tick(); tick();
        chk("reset_state", {p.valid, p.busy, p.done, p.short, p.err, p.x, p.y},
            st(0, 0, 0, 0, 0, 0, 1));
        chk("reset_state0", {p0.valid, p0.busy, p0.x, p0.y}, 4'b0001);
        rst = 1'b0;
        tick();
        chk("idle_hold", {p.valid, p.busy, p.x, p.y}, 4'b0001);
        p.start = 1'b1; p.run_in = 4'd8;
        tick();
        p.start = 1'b0;
        chk("t1_lead", {p.valid, p.busy, p.done, p.short, p.err, p.x, p.y},
            st(1, 1, 0, 0, 0, m_l[0], ~m_l[0]));
        for (int c = 2; c <= 9; c++) begin
            tick();
            chk($sformatf("t1_match_c%0d", c), {p.valid, p.busy, p.x, p.y},
                {2'b11, m_l[0], m_l[0]});
            m_l = lstep(m_l);
        end
        tick();
        chk("t1_tail", {p.valid, p.busy, p.done, p.x, p.y}, {3'b110, m_l[0], ~m_l[0]});
        tick();
        chk("t1_done", {p.valid, p.busy, p.done, p.short, p.err, p.x, p.y},
            st(0, 0, 1, 0, 0, 0, 1));
        tick();
        chk("t1_done_pulse", {p.done, p.busy}, 2'b00);

        // Test 2: RUN_IN=0 rejected with ERR; ABORT alone in IDLE is harmless.
        p.start = 1'b1; p.run_in = 4'd0; p.abort = 1'b1;
        tick();
        p.start = 1'b0; p.abort = 1'b0;
        chk("t2_err", {p.valid, p.busy, p.done, p.short, p.err, p.x, p.y},
            st(0, 0, 0, 0, 1, 0, 1));
        tick();
        chk("t2_err_pulse", {p.err, p.busy, p.x, p.y}, 4'b0001);

        // Test 3: RUN_IN=8 aborted in cycle 5.
        p.start = 1'b1; p.run_in = 4'd8;
        tick();
        p.start = 1'b0;
        chk("t3_lead", {p.valid, p.x, p.y}, {1'b1, m_l[0], ~m_l[0]});
        n_match = 0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            if (p.valid === 1'b1 && p.x === p.y) n_match++;
            chk($sformatf("t3_match_c%0d", c), {p.valid, p.x, p.y}, {1'b1, m_l[0], m_l[0]});
            m_l = lstep(m_l);
            if (c == 5) p.abort = 1'b1;
        end
        tick();
        p.abort = 1'b0;
        chk("t3_tail", {p.valid, p.busy, p.x, p.y}, {2'b11, m_l[0], ~m_l[0]});
        chk("t3_match_count", n_match, 4);
        tick();
        chk("t3_done_short", {p.valid, p.busy, p.done, p.short, p.err, p.x, p.y},
            st(0, 0, 1, 1, 0, 0, 1));
        tick();
        chk("t3_short_clear", {p.done, p.short}, 2'b00);

        // Test 4: START held over a RUN_IN=3 burst; RUN_IN change mid-burst ignored.
        p.start = 1'b1; p.run_in = 4'd3;
        tick();
        p.run_in = 4'd5;
        chk("t4_lead", {p.valid, p.x, p.y}, {1'b1, m_l[0], ~m_l[0]});
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk($sformatf("t4_match_c%0d", c), {p.valid, p.err, p.x, p.y},
                {2'b10, m_l[0], m_l[0]});
            m_l = lstep(m_l);
        end
        tick();
        chk("t4_tail", {p.valid, p.err, p.x, p.y}, {2'b10, m_l[0], ~m_l[0]});
        tick();
        chk("t4_done", {p.busy, p.done, p.short, p.err}, 4'b0100);
        tick();
        p.start = 1'b0;
        chk("t4_relead", {p.valid, p.busy, p.done, p.err, p.x, p.y},
            {4'b1100, m_l[0], ~m_l[0]});
        for (int c = 8; c <= 12; c++) begin
            tick();
            chk($sformatf("t4b_match_c%0d", c), {p.valid, p.x, p.y}, {1'b1, m_l[0], m_l[0]});
            m_l = lstep(m_l);
        end
        tick();
        chk("t4b_tail", {p.valid, p.x, p.y}, {1'b1, m_l[0], ~m_l[0]});
        tick();
        chk("t4b_done", {p.busy, p.done, p.short}, 3'b010);

        // Test 5: reset in cycle 4 of a RUN_IN=15 burst.
        p.start = 1'b1; p.run_in = 4'd15;
        tick();
        p.start = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk($sformatf("t5_match_c%0d", c), {p.valid, p.x, p.y}, {1'b1, m_l[0], m_l[0]});
            m_l = lstep(m_l);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_idle", {p.valid, p.busy, p.done, p.short, p.err, p.x, p.y},
            st(0, 0, 0, 0, 0, 0, 1));
        tick();
        chk("t5_no_done", {p.done, p.busy}, 2'b00);
        m_l = 8'hA5;
        p.start = 1'b1; p.run_in = 4'd1;
        tick();
        p.start = 1'b0;
        chk("t5_seed_lead", {p.x, p.y}, 2'b10);
        tick();
        chk("t5_seed_match", {p.valid, p.x, p.y}, {1'b1, m_l[0], m_l[0]});
        m_l = lstep(m_l);
        tick();
        chk("t5_seed_tail", {p.valid, p.x, p.y}, 3'b101);
        tick();
        chk("t5_done", {p.done, p.short}, 2'b10);

        // Test 6: SEED=0 promoted to 1; START beats ABORT in IDLE; full 15-pair run.
        p0.start = 1'b1; p0.run_in = 4'd15; p0.abort = 1'b1;
        tick();
        p0.start = 1'b0; p0.abort = 1'b0;
        chk("t6_lead", {p0.valid, p0.busy, p0.x, p0.y}, 4'b1110);
        n_match = 0;
        for (int c = 2; c <= 16; c++) begin
            tick();
            if (p0.valid === 1'b1 && p0.x === p0.y) n_match++;
            chk($sformatf("t6_match_c%0d", c), {p0.valid, p0.x, p0.y},
                {1'b1, m_l0[0], m_l0[0]});
            m_l0 = lstep(m_l0);
        end
        tick();
        chk("t6_tail", {p0.valid, p0.x, p0.y}, {1'b1, m_l0[0], ~m_l0[0]});
        chk("t6_match_count", n_match, 15);
        tick();
        chk("t6_done", {p0.busy, p0.done, p0.short, p0.err, p0.x, p0.y}, 6'b010001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
